// File: rtl/mem_stage_if.sv
// mem_stage_if: memory request/ready bus between the
// memory-access stage (master) and data memory (slave).
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with stall and WB register.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] ALU_out_Ex,
  input  logic [63:0] shifter2_out_Ex,
  input  logic [63:0] MUL_out_Ex,
  input  logic [63:0] DataB_Ex,
  input  logic        MemWrite_Ex,
  input  logic        MemRead_Ex,
  input  logic        RegWrite_Ex,
  input  logic [1:0]  RegWrSrc_Ex,
  input  logic [4:0]  Rd_Ex,
  mem_stage_if.master mem,
  output logic        stall,
  output logic [63:0] Fwd_Data,
  output logic [63:0] WrData_Mem,
  output logic [4:0]  Rd_Mem,
  output logic        RegWrite_Mem,
  output logic        mem_error
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nx;
  logic        mem_op;
  logic        in_acc;
  logic        tmo;
  logic        done;
  logic        wb_take;
  logic [63:0] ld_data;

  assign mem_op = MemRead_Ex | MemWrite_Ex;
  assign in_acc = (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt;

  assign tmo = in_acc && (cnt >= CW'(TIMEOUT_CYCLES));

  // Count ACCESS cycles; IDLE holds it at zero for the next entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!in_acc)
      cnt <= '0;
    else if (!tmo)
      cnt <= cnt + CW'(1);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mem_error <= 1'b0;
    else if (tmo)
      mem_error <= 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign tmo       = 1'b0;
  assign mem_error = 1'b0;
`endif

  assign done = in_acc & ~tmo & mem.mem_ready;

  assign stall = ~reset &
    (in_acc ? ~(done | tmo) : mem_op);

  assign wb_take = ~stall & ~tmo;

  assign mem.mem_req   = in_acc & ~tmo;
  assign mem.mem_we    = mem.mem_req & MemWrite_Ex;
  assign mem.mem_addr  = mem.mem_req ? ALU_out_Ex : '0;
  assign mem.mem_wdata = mem.mem_req ? DataB_Ex : '0;

  // A store (even with MemRead set) never returns load data
  assign ld_data = MemWrite_Ex ? '0 : mem.mem_rdata;

  // Write-back source select, shared with forwarding
  always_comb begin
    Fwd_Data = ALU_out_Ex;
    unique case (1'b1)
      RegWrSrc_Ex == 2'b00: Fwd_Data = ALU_out_Ex;
      RegWrSrc_Ex == 2'b01: Fwd_Data = ld_data;
      RegWrSrc_Ex == 2'b10: Fwd_Data = shifter2_out_Ex;
      RegWrSrc_Ex == 2'b11: Fwd_Data = MUL_out_Ex;
      default:              Fwd_Data = ALU_out_Ex;
    endcase
  end

  // Next state: enter ACCESS on a memory op, leave on done or abort
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE:
        if (mem_op) state_nx = ACCESS;
      state == ACCESS:
        if (done || tmo) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // WB register: result when the op retires, bubble otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WrData_Mem   <= '0;
      Rd_Mem       <= '0;
      RegWrite_Mem <= 1'b0;
    end else if (wb_take) begin
      WrData_Mem   <= Fwd_Data;
      Rd_Mem       <= Rd_Ex;
      RegWrite_Mem <= RegWrite_Ex;
    end else begin
      WrData_Mem   <= '0;
      Rd_Mem       <= '0;
      RegWrite_Mem <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus random ops against a
// cycle-count and result reference model.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [63:0] ALU_out_Ex;
  logic [63:0] shifter2_out_Ex;
  logic [63:0] MUL_out_Ex;
  logic [63:0] DataB_Ex;
  logic        MemWrite_Ex;
  logic        MemRead_Ex;
  logic        RegWrite_Ex;
  logic [1:0]  RegWrSrc_Ex;
  logic [4:0]  Rd_Ex;
  logic        stall;
  logic [63:0] Fwd_Data;
  logic [63:0] WrData_Mem;
  logic [4:0]  Rd_Mem;
  logic        RegWrite_Mem;
  logic        mem_error;

  int checks = 0;
  int errors = 0;

  mem_stage_if mem_if ();

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ALU_out_Ex      (ALU_out_Ex),
    .shifter2_out_Ex (shifter2_out_Ex),
    .MUL_out_Ex      (MUL_out_Ex),
    .DataB_Ex        (DataB_Ex),
    .MemWrite_Ex     (MemWrite_Ex),
    .MemRead_Ex      (MemRead_Ex),
    .RegWrite_Ex     (RegWrite_Ex),
    .RegWrSrc_Ex     (RegWrSrc_Ex),
    .Rd_Ex           (Rd_Ex),
    .mem             (mem_if),
    .stall           (stall),
    .Fwd_Data        (Fwd_Data),
    .WrData_Mem      (WrData_Mem),
    .Rd_Mem          (Rd_Mem),
    .RegWrite_Mem    (RegWrite_Mem),
    .mem_error       (mem_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_sel(
    input logic [1:0] src, input logic [63:0] alu,
    input logic [63:0] sh, input logic [63:0] mul,
    input logic [63:0] ld);
    case (src)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return sh;
      default: return mul;
    endcase
  endfunction

  task automatic drive(input logic [63:0] alu,
                       input logic [63:0] sh,
                       input logic [63:0] mul,
                       input logic [63:0] db,
                       input logic rd_en, input logic wr_en,
                       input logic rw, input logic [1:0] src,
                       input logic [4:0] rd);
    ALU_out_Ex      = alu;
    shifter2_out_Ex = sh;
    MUL_out_Ex      = mul;
    DataB_Ex        = db;
    MemRead_Ex      = rd_en;
    MemWrite_Ex     = wr_en;
    RegWrite_Ex     = rw;
    RegWrSrc_Ex     = src;
    Rd_Ex           = rd;
  endtask

  // One instruction through the stage; memory answers after wt
  // requested cycles. Model: a memory op stalls wt+1 cycles and
  // requests wt+1 cycles; a non-memory op never stalls.
  task automatic run_op(input logic [63:0] alu,
                        input logic [63:0] sh,
                        input logic [63:0] mul,
                        input logic [63:0] db,
                        input logic rd_en, input logic wr_en,
                        input logic rw, input logic [1:0] src,
                        input logic [4:0] rd, input int wt,
                        input logic [63:0] rdv);
    int nreq = 0;
    int nstall = 0;
    bit fin = 0;
    bit st;
    bit is_mem = rd_en | wr_en;
    int exp_cyc = is_mem ? wt + 1 : 0;
    logic [63:0] exp = ref_sel(src, alu, sh, mul,
                               wr_en ? 64'd0 : rdv);
    @(negedge clk);
    drive(alu, sh, mul, db, rd_en, wr_en, rw, src, rd);
    mem_if.mem_ready = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      #1;
      if (mem_if.mem_req) begin
        nreq++;
        chk("mem_addr", mem_if.mem_addr, alu);
        chk("mem_we", 64'(mem_if.mem_we), 64'(wr_en));
        chk("mem_wdata", mem_if.mem_wdata, db);
        mem_if.mem_ready = (nreq == wt + 1);
        mem_if.mem_rdata = (nreq == wt + 1) ? rdv
                         : {$urandom, $urandom};
      end else begin
        mem_if.mem_ready = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = {$urandom, $urandom};
      end
      #1;
      st = stall;
      if (st) nstall++;
      else chk("fwd_data", Fwd_Data, exp);
      @(posedge clk);
      #1;
      if (!st) begin
        chk("wb_data", WrData_Mem, exp);
        chk("wb_rd", 64'(Rd_Mem), 64'(rd));
        chk("wb_we", 64'(RegWrite_Mem), 64'(rw));
        fin = 1;
      end else begin
        chk("bubble_we", 64'(RegWrite_Mem), 64'd0);
        chk("bubble_data", WrData_Mem, 64'd0);
      end
      if (!fin) @(negedge clk);
    end
    mem_if.mem_ready = 1'b0;
    chk("stall_cycles", 64'(nstall), 64'(exp_cyc));
    chk("req_cycles", 64'(nreq), 64'(exp_cyc));
  endtask

  initial begin
    logic [1:0] src;
    logic rd_en;
    logic wr_en;
    reset = 1'b1;
    drive('0, '0, '0, '0, 0, 0, 0, 2'd0, 5'd0);
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    #1;
    chk("rst_req", 64'(mem_if.mem_req), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wb_data", WrData_Mem, 64'd0);
    chk("rst_wb_rd", 64'(Rd_Mem), 64'd0);
    chk("rst_wb_we", 64'(RegWrite_Mem), 64'd0);
    chk("rst_err", 64'(mem_error), 64'd0);
    #11 reset = 1'b0;

    run_op(64'h1234, 0, 0, 0, 0, 0, 1, 2'd0, 5'd5, 0, 0);
    run_op(64'h40, 0, 0, 0, 1, 0, 1, 2'd1, 5'd7, 0,
           64'hDEADBEEF);
    run_op(64'h80, 0, 0, 64'h55, 0, 1, 0, 2'd0, 5'd9, 3, 0);
    run_op(0, 64'h8, 64'h21, 0, 0, 0, 1, 2'd2, 5'd1, 0, 0);
    run_op(0, 64'h8, 64'h21, 0, 0, 0, 1, 2'd3, 5'd2, 0, 0);
    // both read and write: behaves as a store
    run_op(64'hC0, 64'h3, 0, 64'hAA, 1, 1, 1, 2'd2, 5'd4, 1,
           64'h777);
    run_op(64'h48, 0, 0, 0, 1, 0, 1, 2'd1, 5'd8, 2,
           64'h1122334455667788);

    // reset in the middle of an access
    @(negedge clk);
    drive(64'h100, 0, 0, 0, 1, 0, 1, 2'd1, 5'd3);
    mem_if.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", 64'(mem_if.mem_req), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 64'(mem_if.mem_req), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_wb", WrData_Mem, 64'd0);
    chk("mid_rst_we", 64'(RegWrite_Mem), 64'd0);
    drive('0, '0, '0, '0, 0, 0, 0, 2'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(64'h200, 0, 0, 0, 1, 0, 1, 2'd1, 5'd6, 1,
           64'hCAFE);

    for (int i = 0; i < 40; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      wr_en = 1'($urandom_range(0, 1));
      src   = 2'($urandom_range(0, 3));
      if (src == 2'd1 && !(rd_en && !wr_en)) src = 2'd0;
      run_op({$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom},
             rd_en, wr_en, 1'($urandom_range(0, 1)), src,
             5'($urandom_range(0, 31)), $urandom_range(0, 3),
             {$urandom, $urandom});
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int nreq = 0;
      int nstall = 0;
      bit fin = 0;
      @(negedge clk);
      drive(64'h300, 0, 0, 0, 1, 0, 1, 2'd1, 5'd11);
      mem_if.mem_ready = 1'b0;
      for (int c = 0; c < 32 && !fin; c++) begin
        #1;
        if (mem_if.mem_req) nreq++;
        if (stall) nstall++;
        else fin = 1;
        @(posedge clk);
        #1;
        if (!fin) @(negedge clk);
      end
      chk("tmo_req_cycles", 64'(nreq), 64'd4);
      chk("tmo_stall_cycles", 64'(nstall), 64'd5);
      chk("tmo_wb_we", 64'(RegWrite_Mem), 64'd0);
      chk("tmo_err", 64'(mem_error), 64'd1);
      run_op(64'h99, 0, 0, 0, 0, 0, 1, 2'd0, 5'd12, 0, 0);
      chk("tmo_err_sticky", 64'(mem_error), 64'd1);
    end
`else
    chk("err_tied", 64'(mem_error), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipelined CPU, sitting directly downstream of the execution stage and upstream of write-back. It takes the registered Exec results and control and performs loads and stores through a ready/request memory handshake. It stalls the upstream stages while an access is outstanding and selects the write-back value. It registers the write-back data, destination and write enable for the WB stage and the forwarding unit.

## Interface

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without `mem_ready` before abort (`MEM_TIMEOUT_EN` builds only).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ALU_out_Ex  in  64  ALU result from Exec; also the memory byte address.
- shifter2_out_Ex  in  64  shifter result from Exec.
- MUL_out_Ex  in  64  multiplier low result from Exec.
- DataB_Ex  in  64  store data.
- MemWrite_Ex, MemRead_Ex, RegWrite_Ex  in  1 each  control from Exec.
- RegWrSrc_Ex  in  2  write-back source: 00 ALU, 01 memory, 10 shifter, 11 multiplier.
- Rd_Ex  in  5  destination register.
- mem_req  out  1  access request, held until `mem_ready` or abort.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  64  equals ALU_out_Ex during a request.
- mem_wdata  out  64  equals DataB_Ex during a request.
- mem_rdata  in  64  load data, valid when `mem_ready`=1.
- mem_ready  in  1  access completes this cycle.
- stall  out  1  combinational; upstream stages hold their registers while 1.
- Fwd_Data  out  64  combinational selected result for forwarding; meaningful only when stall=0.
- WrData_Mem  out  64  registered write-back data.
- Rd_Mem  out  5  registered destination.
- RegWrite_Mem  out  1  registered write enable.
- mem_error  out  1  sticky timeout flag (tied 0 without `MEM_TIMEOUT_EN`).

## Operation

- FSM states: IDLE, ACCESS.
- In IDLE with MemRead_Ex|MemWrite_Ex=0:
  - stall=0.
  - WB register loads {selected result, Rd_Ex, RegWrite_Ex}.
- In IDLE with a memory op:
  - stall=1, mem_req=0.
  - WB register loads a bubble (RegWrite_Mem=0, WrData_Mem=0, Rd_Mem=0).
  - Next state ACCESS.
- In ACCESS, mem_req=1 and mem_we=MemWrite_Ex.
  - If mem_ready=0: stall=1, WB bubble, stay in ACCESS.
  - If mem_ready=1: stall=0, WB loads the result (mem_rdata when RegWrSrc_Ex=01) with Rd_Ex and RegWrite_Ex; next state IDLE.
- Result select by RegWrSrc_Ex. Fwd_Data is the same mux output.
- MemRead_Ex and MemWrite_Ex both 1: treated as a store; the load data is ignored.
- A store with RegWrite_Ex=1 writes back the selected value as commanded; the stage does not police it.

## Timing

- Reset values: state IDLE, all registered outputs 0, mem_req=0, mem_error=0, timeout counter 0.
- Non-memory instruction: 1 cycle in the stage; WB outputs valid the edge after it enters.
- Memory op with zero-wait memory (mem_ready=1 on the first ACCESS cycle): 2 cycles in the stage, 1 stall cycle.
- Each extra cycle that mem_ready is low adds 1 stall cycle.
- mem_ready while mem_req=0 is ignored.
- Back-to-back memory ops: the second enters IDLE the cycle after completion and always spends 1 IDLE stall cycle before ACCESS.
- Reset mid-ACCESS: mem_req drops immediately (asynchronous), and the in-flight op is discarded.
- Upstream must keep all *_Ex inputs stable while stall=1.

## Configuration

- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in ACCESS and clears on entry to ACCESS.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, mem_req drops, mem_error sets sticky until reset, the op completes as a bubble (RegWrite_Mem=0), stall=0 that cycle, and the state returns to IDLE.
- Undefined: no counter; ACCESS waits indefinitely; mem_error is tied 0.

## Test plan

- ALU op, RegWrSrc=00, ALU_out_Ex=0x1234, Rd=5, RegWrite=1 -> next edge WrData_Mem=0x1234, Rd_Mem=5, RegWrite_Mem=1, stall never 1.
- Load, addr 0x40, memory returns 0xDEADBEEF with mem_ready on the first ACCESS cycle -> stall high exactly 1 cycle; mem_addr=0x40, mem_we=0; WrData_Mem=0xDEADBEEF the following edge.
- Store, addr 0x80, DataB=0x55, mem_ready delayed 3 cycles -> mem_req held 4 cycles with mem_wdata=0x55, mem_we=1; stall 4 cycles; RegWrite_Mem=0 throughout.
- RegWrSrc=10/11 with shifter=0x8, mul=0x21 -> WrData_Mem=0x8, then 0x21 on consecutive edges.
- Reset asserted mid-ACCESS -> mem_req, stall and all outputs 0 without a clock edge; after release, a new op proceeds normally.
- `MEM_TIMEOUT_EN`, TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req drops after 4 ACCESS cycles; mem_error=1 stays set; RegWrite_Mem=0; pipeline resumes.
